sm_trace_buffer: RTL and testbench
==================================

SM_TRACE_BUFFER -- requirements
Module: sm_trace_buffer

Interface
REQ-001 Parameter DEPTH, 16, number of trace entries; power of two, minimum 4.
REQ-002 Parameter POST_TRIG, 8, entries captured after the trigger entry; range 0..DEPTH-1.
REQ-003 Parameter NCYCLE, 120, valid-cycle timeout limit counted from arm.
REQ-004 Parameter AW, log2(DEPTH), entry address width.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 valid  in  1  CPU executed one instruction this cycle; sample qualifier.
REQ-008 pc  in  32  word PC of the executed instruction.
REQ-009 instr  in  32  executed instruction word.
REQ-010 watch  in  32  watched register value ($v0).
REQ-011 arm  in  1  one-cycle pulse; clears buffer and starts capture.
REQ-012 trigEn  in  1  enables PC-match trigger.
REQ-013 trigPc  in  32  trigger PC value.
REQ-014 rdAddr  in  AW  read index; 0 = oldest stored entry.
REQ-015 rdPc, rdInstr, rdWatch  out  32 each  entry at rdAddr, registered.
REQ-016 count  out  AW+1  number of valid stored entries, 0..DEPTH.
REQ-017 cycle  out  32  valid cycles since last arm.
REQ-018 busy  out  1  state is ARMED or POST.
REQ-019 done  out  1  state is DONE.
REQ-020 timeout  out  1  DONE was reached by timeout, not trigger.

Function
REQ-021 States IDLE, ARMED, POST, DONE; the machine SHALL leave reset in IDLE.
REQ-022 arm in any state SHALL clear count, cycle, timeout, write pointer, and enter ARMED next cycle; arm has priority over every other event.
REQ-023 In ARMED or POST, each valid cycle SHALL write {pc, instr, watch} at the write pointer, increment pointer modulo DEPTH, and increment count saturating at DEPTH.
REQ-024 On wrap-around the oldest entry SHALL be overwritten; oldest index = wrPtr when count = DEPTH, else 0.
REQ-025 ARMED -> POST when valid and trigEn and pc == trigPc; the triggering sample SHALL be stored.
REQ-026 With POST_TRIG = 0, a trigger SHALL go ARMED -> DONE directly after storing the trigger sample.
REQ-027 POST SHALL store exactly POST_TRIG further valid samples, then enter DONE; no writes in DONE or IDLE.
REQ-028 cycle SHALL increment on each valid cycle in ARMED/POST, saturating at 2^32-1.
REQ-029 In ARMED, when a valid sample brings cycle to NCYCLE without trigger, that sample SHALL be stored and the machine SHALL enter DONE with timeout = 1; trigger wins if both occur on the same sample (timeout = 0).
REQ-030 Timeout SHALL NOT apply in POST.
REQ-031 Read latency SHALL be one cycle: rd* reflect entry (oldest + rdAddr) mod DEPTH sampled at the previous edge; rdAddr >= count returns stale contents, no error.
REQ-032 Reads in any state SHALL be permitted; a read of the entry written in the same cycle SHALL return the old data.

Reset
REQ-033 rst SHALL asynchronously force state IDLE, count 0, cycle 0, wrPtr 0, timeout 0, rd* 0; storage array contents are not reset.
REQ-034 rst asserted mid-capture SHALL abandon capture; after release the block stays IDLE until arm.

Structure
REQ-035 State encoding and entry record layout {pc, instr, watch} SHALL reside in shared package sm_trace_pkg.
REQ-036 Storage SHALL be a sub-module sm_trace_ram (one write port, one registered read port, no reset) to allow block-RAM inference.

Verification
REQ-037 arm, trigEn=0, 20 valid samples pc=0..19 with DEPTH=16 -> count=16, rdAddr 0 returns pc=4, rdAddr 15 returns pc=19, busy=1.
REQ-038 arm, trigPc=5, pc=0..30 valid -> DONE after pc=13 stored, timeout=0, count=14, rdAddr 5 returns pc=5.
REQ-039 arm, trigEn=0, NCYCLE=120, 130 valid samples -> DONE on sample 120, timeout=1, cycle=120, last entry pc=119.
REQ-040 POST_TRIG=0, trigger at pc=3 -> DONE next cycle, count=4, no further writes.
REQ-041 rst pulse during POST, then valid samples -> IDLE, count=0, rd* 0, no writes; subsequent arm restarts normally.
REQ-042 arm asserted in the same cycle as a trigger match -> ARMED, count=0, sample discarded.

Source files
------------

// File: rtl/sm_trace_pkg.sv
// Shared types for the trace buffer: controller states and the stored entry record.
package sm_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  // One captured instruction: pc in the top word, watched register in the bottom word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] watch;
  } trace_entry_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sm_trace_ram.sv
// Trace storage: one write port, one registered read port, no reset so it maps to block RAM.
// A read of the address being written in the same cycle returns the previous contents.
module sm_trace_ram
  import sm_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           we_i,
  input  logic [AW-1:0]  wr_addr_i,
  input  trace_entry_t   wr_data_i,
  input  logic [AW-1:0]  rd_addr_i,
  output trace_entry_t   rd_data_o
);

  trace_entry_t mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Registered read port (read-before-write).
  always_ff @(posedge clk) begin
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/sm_trace_buffer.sv
// Instruction trace buffer: circular capture of {pc, instr, watch} after arm,
// stopped by a PC-match trigger plus POST_TRIG samples, or by a valid-cycle timeout.
module sm_trace_buffer
  import sm_trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int NCYCLE    = 120,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic [31:0]   pc,
  input  logic [31:0]   instr,
  input  logic [31:0]   watch,
  input  logic          arm,
  input  logic          trigEn,
  input  logic [31:0]   trigPc,
  input  logic [AW-1:0] rdAddr,
  output logic [31:0]   rdPc,
  output logic [31:0]   rdInstr,
  output logic [31:0]   rdWatch,
  output logic [AW:0]   count,
  output logic [31:0]   cycle,
  output logic          busy,
  output logic          done,
  output logic          timeout
);

  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]  POST_CNT = (AW+1)'(POST_TRIG);
  localparam logic [31:0]  NCYCLE_W = 32'(NCYCLE);

  trace_state_e  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   cycle_q, cycle_d;
  logic          timeout_q, timeout_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic          rd_ok_q;
  logic          we;
  logic          trig_hit;
  logic          post_last;
  logic [AW-1:0] oldest;
  logic [AW-1:0] rd_idx;
  trace_entry_t  wr_entry;
  trace_entry_t  rd_entry;

  assign trig_hit  = trigEn && (pc == trigPc);
  assign post_last = (({1'b0, post_cnt_q}) + (AW+1)'(1)) == POST_CNT;
  // Once the ring has wrapped, the oldest entry sits where the next write will land.
  assign oldest    = (count_q == FULL_CNT) ? wr_ptr_q : '0;
  assign rd_idx    = oldest + rdAddr;
  assign wr_entry  = '{pc: pc, instr: instr, watch: watch};

  // Next-state and capture control; arm overrides everything else.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    cycle_d    = cycle_q;
    timeout_d  = timeout_q;
    post_cnt_d = post_cnt_q;
    we         = 1'b0;
    if (arm) begin
      state_d    = ST_ARMED;
      wr_ptr_d   = '0;
      count_d    = '0;
      cycle_d    = '0;
      timeout_d  = 1'b0;
      post_cnt_d = '0;
    end else if (valid && (state_q == ST_ARMED || state_q == ST_POST)) begin
      we       = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (count_q != FULL_CNT) count_d = count_q + (AW+1)'(1);
      cycle_d  = sat_inc32(cycle_q);
      if (state_q == ST_ARMED) begin
        if (trig_hit) begin
          post_cnt_d = '0;
          state_d    = (POST_TRIG == 0) ? ST_DONE : ST_POST;
        end else if (cycle_d == NCYCLE_W) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end else begin
        post_cnt_d = post_cnt_q + AW'(1);
        if (post_last) state_d = ST_DONE;
      end
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      cycle_q    <= '0;
      timeout_q  <= 1'b0;
      post_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      cycle_q    <= cycle_d;
      timeout_q  <= timeout_d;
      post_cnt_q <= post_cnt_d;
    end
  end

  // The RAM read register has no reset, so read data is forced to zero until the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_ok_q <= 1'b0;
    else     rd_ok_q <= 1'b1;
  end

  sm_trace_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .we_i      (we),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_idx),
    .rd_data_o (rd_entry)
  );

  assign rdPc    = rd_ok_q ? rd_entry.pc    : 32'd0;
  assign rdInstr = rd_ok_q ? rd_entry.instr : 32'd0;
  assign rdWatch = rd_ok_q ? rd_entry.watch : 32'd0;
  assign count   = count_q;
  assign cycle   = cycle_q;
  assign busy    = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign done    = (state_q == ST_DONE);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Randomized and directed bench for sm_trace_buffer; two instances (POST_TRIG 8 and 0)
// share inputs and are compared each cycle against a history-log reference model.
module tb_sm_trace_buffer;

  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int NCYCLE = 120;

  localparam int S_IDLE  = 0;
  localparam int S_ARMED = 1;
  localparam int S_POST  = 2;
  localparam int S_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [31:0]   pc = '0, instr = '0, watch = '0;
  logic          arm = 1'b0;
  logic          trigEn = 1'b0;
  logic [31:0]   trigPc = '0;
  logic [AW-1:0] rdAddr = '0;

  logic [31:0]   rd_pc_a, rd_instr_a, rd_watch_a, cycle_a;
  logic [AW:0]   count_a;
  logic          busy_a, done_a, timeout_a;
  logic [31:0]   rd_pc_b, rd_instr_b, rd_watch_b, cycle_b;
  logic [AW:0]   count_b;
  logic          busy_b, done_b, timeout_b;

  int checks = 0;
  int errors = 0;

  // Reference model: full log of stored samples since arm; the ring view is the last DEPTH of them.
  logic [95:0] hist [2][256];
  int          n    [2];
  int          cyc  [2];
  int          st   [2];
  int          post [2];
  bit          to   [2];
  int          pt   [2];
  logic [95:0] exp_rd [2];
  bit          exp_ok [2];

  always #5 clk = ~clk;

  sm_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(8), .NCYCLE(NCYCLE)) u_dut_a (
    .clk(clk), .rst(rst), .valid(valid), .pc(pc), .instr(instr), .watch(watch),
    .arm(arm), .trigEn(trigEn), .trigPc(trigPc), .rdAddr(rdAddr),
    .rdPc(rd_pc_a), .rdInstr(rd_instr_a), .rdWatch(rd_watch_a), .count(count_a),
    .cycle(cycle_a), .busy(busy_a), .done(done_a), .timeout(timeout_a));

  sm_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(0), .NCYCLE(NCYCLE)) u_dut_b (
    .clk(clk), .rst(rst), .valid(valid), .pc(pc), .instr(instr), .watch(watch),
    .arm(arm), .trigEn(trigEn), .trigPc(trigPc), .rdAddr(rdAddr),
    .rdPc(rd_pc_b), .rdInstr(rd_instr_b), .rdWatch(rd_watch_b), .count(count_b),
    .cycle(cycle_b), .busy(busy_b), .done(done_b), .timeout(timeout_b));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int stored(input int k);
    return (n[k] < DEPTH) ? n[k] : DEPTH;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      n[k] = 0; cyc[k] = 0; st[k] = S_IDLE; post[k] = 0; to[k] = 1'b0;
      exp_ok[k] = 1'b1; exp_rd[k] = '0;
    end
  endtask

  // Apply the capture rules to the inputs that the coming rising edge will sample.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int c;
      c = stored(k);
      exp_ok[k] = (int'(rdAddr) < c);
      if (exp_ok[k]) exp_rd[k] = hist[k][n[k] - c + int'(rdAddr)];
      if (arm) begin
        st[k] = S_ARMED; n[k] = 0; cyc[k] = 0; to[k] = 1'b0; post[k] = 0;
      end else if (valid && (st[k] == S_ARMED || st[k] == S_POST)) begin
        hist[k][n[k]] = {pc, instr, watch};
        n[k]++;
        cyc[k]++;
        if (st[k] == S_ARMED) begin
          if (trigEn && pc == trigPc) begin
            st[k] = (pt[k] == 0) ? S_DONE : S_POST;
            post[k] = 0;
          end else if (cyc[k] == NCYCLE) begin
            st[k] = S_DONE; to[k] = 1'b1;
          end
        end else begin
          post[k]++;
          if (post[k] == pt[k]) st[k] = S_DONE;
        end
      end
    end
  endtask

  task automatic cmp_inst(input int k, input logic [31:0] cnt, input logic [31:0] cy,
                          input logic b, input logic d, input logic t,
                          input logic [31:0] rp, input logic [31:0] ri, input logic [31:0] rw);
    chk($sformatf("count%0d", k), cnt, 32'(stored(k)));
    chk($sformatf("cycle%0d", k), cy, 32'(cyc[k]));
    chk($sformatf("busy%0d", k), {31'd0, b}, {31'd0, (st[k] == S_ARMED || st[k] == S_POST)});
    chk($sformatf("done%0d", k), {31'd0, d}, {31'd0, (st[k] == S_DONE)});
    chk($sformatf("timeout%0d", k), {31'd0, t}, {31'd0, to[k]});
    if (exp_ok[k]) begin
      chk($sformatf("rdPc%0d", k), rp, exp_rd[k][95:64]);
      chk($sformatf("rdInstr%0d", k), ri, exp_rd[k][63:32]);
      chk($sformatf("rdWatch%0d", k), rw, exp_rd[k][31:0]);
    end
  endtask

  task automatic check_all();
    cmp_inst(0, 32'(count_a), cycle_a, busy_a, done_a, timeout_a, rd_pc_a, rd_instr_a, rd_watch_a);
    cmp_inst(1, 32'(count_b), cycle_b, busy_b, done_b, timeout_b, rd_pc_b, rd_instr_b, rd_watch_b);
  endtask

  // One clock: drive inputs at the falling edge, update the model, check after the rising edge.
  task automatic step(input bit a, input bit v, input logic [31:0] p, input bit te,
                      input logic [31:0] tp, input logic [AW-1:0] ra);
    @(negedge clk);
    arm = a; valid = v; pc = p; instr = $urandom; watch = $urandom;
    trigEn = te; trigPc = tp; rdAddr = ra;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset asserted between edges; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    arm = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    pt[0] = 8;
    pt[1] = 0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Samples while idle are ignored.
    for (int i = 0; i < 4; i++) step(0, 1, 32'(i), 0, 0, 0);
    $display("idle: count_a=%0d busy_a=%0b", count_a, busy_a);

    // Wrap-around with no trigger.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 32'(i), 0, 0, 0);
    step(0, 0, 0, 0, 0, 4'd0);
    chk("wrap_rd0", rd_pc_a, 32'd4);
    step(0, 0, 0, 0, 0, 4'd15);
    chk("wrap_rd15", rd_pc_a, 32'd19);
    chk("wrap_count", 32'(count_a), 32'd16);
    chk("wrap_busy", {31'd0, busy_a}, 32'd1);
    $display("wrap: count=%0d rd15=%0d", count_a, rd_pc_a);

    // Trigger at pc=5 with 8 post samples.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 30; i++) step(0, 1, 32'(i), 1, 32'd5, 0);
    step(0, 0, 0, 1, 32'd5, 4'd5);
    chk("trig_done", {31'd0, done_a}, 32'd1);
    chk("trig_timeout", {31'd0, timeout_a}, 32'd0);
    chk("trig_count", 32'(count_a), 32'd14);
    chk("trig_rd5", rd_pc_a, 32'd5);
    chk("trig0_count", 32'(count_b), 32'd6);
    $display("trigger: count_a=%0d count_b=%0d", count_a, count_b);

    // Timeout after NCYCLE valid samples.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 130; i++) step(0, 1, 32'(i), 0, 0, 0);
    step(0, 0, 0, 0, 0, 4'd15);
    chk("to_done", {31'd0, done_a}, 32'd1);
    chk("to_flag", {31'd0, timeout_a}, 32'd1);
    chk("to_cycle", cycle_a, 32'd120);
    chk("to_last", rd_pc_a, 32'd119);
    $display("timeout: cycle=%0d last=%0d", cycle_a, rd_pc_a);

    // Zero post-trigger samples (second instance).
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 10; i++) step(0, 1, 32'(i), 1, 32'd3, 0);
    step(0, 0, 0, 1, 32'd3, 4'd3);
    chk("pt0_done", {31'd0, done_b}, 32'd1);
    chk("pt0_count", 32'(count_b), 32'd4);
    chk("pt0_rd3", rd_pc_b, 32'd3);
    $display("post0: count_b=%0d", count_b);

    // Reset during POST abandons capture.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 32'(i), 1, 32'd2, 0);
    chk("mid_busy", {31'd0, busy_a}, 32'd1);
    do_reset();
    chk("rst_rdpc", rd_pc_a, 32'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 32'(i), 1, 32'd2, 0);
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 32'(100 + i), 0, 0, 0);
    step(0, 0, 0, 0, 0, 4'd0);
    chk("rearm_count", 32'(count_a), 32'd3);
    chk("rearm_rd0", rd_pc_a, 32'd100);
    $display("reset-restart: count=%0d", count_a);

    // arm coinciding with a trigger match discards the sample.
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 32'd7, 1, 32'd7, 0);
    chk("armtrig_busy", {31'd0, busy_a}, 32'd1);
    chk("armtrig_count", 32'(count_a), 32'd0);
    chk("armtrig_done", {31'd0, done_a}, 32'd0);
    $display("arm+trigger: count=%0d busy=%0b", count_a, busy_a);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) != 0),
             32'($urandom_range(0, 23)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 23)), AW'($urandom_range(0, DEPTH - 1)));
      end
    end
    $display("random: done, checks so far %0d", checks);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
